// File: rtl/mandel_view_if.sv
// View-parameter and request bundle between mandel_view_ctrl, the input debouncers and render_mandel.
// MANDEL_AUTOZOOM_EN adds the auto_en request line.
interface mandel_view_if #(
  parameter int FP_WIDTH = 25
);
  logic                       frame;
  logic                       sel;
  logic                       up;
  logic                       dn;
  logic                       render_busy;
`ifdef MANDEL_AUTOZOOM_EN
  logic                       auto_en;
`endif
  logic                       render_start;
  logic signed [FP_WIDTH-1:0] x_start;
  logic signed [FP_WIDTH-1:0] y_start;
  logic signed [FP_WIDTH-1:0] step;
  logic [1:0]                 mode;
  logic                       reject;
  logic                       idle;

  modport master (
`ifdef MANDEL_AUTOZOOM_EN
    input  auto_en,
`endif
    input  frame, sel, up, dn, render_busy,
    output render_start, x_start, y_start, step, mode, reject, idle
  );

  modport slave (
`ifdef MANDEL_AUTOZOOM_EN
    output auto_en,
`endif
    output frame, sel, up, dn, render_busy,
    input  render_start, x_start, y_start, step, mode, reject, idle
  );
endinterface

// File: rtl/mandel_view_ctrl.sv
// Pan/zoom sequencer for render_mandel: new view two cycles after the frame request, requests dropped outside IDLE.
// MANDEL_AUTOZOOM_EN enables auto zoom-in on frame with auto_en, reloading the home view when the zoom limit is hit.
module mandel_view_ctrl #(
  parameter int                         FP_WIDTH     = 25,
  parameter logic signed [FP_WIDTH-1:0] X_START      = 25'h1900000,
  parameter logic signed [FP_WIDTH-1:0] Y_START      = 25'h1D00000,
  parameter logic signed [FP_WIDTH-1:0] STEP_MAX     = 25'h0008000,
  parameter int                         FB_WIDTH     = 320,
  parameter int                         FB_HEIGHT    = 180,
  parameter int                         MOVE_SHIFT   = 4,
  parameter int                         BUSY_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  mandel_view_if.master vif
);

  localparam logic [1:0] MODE_HORZ = 2'd0;
  localparam logic [1:0] MODE_VERT = 2'd1;
  localparam logic [1:0] MODE_ZOOM = 2'd2;

  localparam logic signed [FP_WIDTH-1:0] HALF_W = FP_WIDTH'(FB_WIDTH / 2);
  localparam logic signed [FP_WIDTH-1:0] HALF_H = FP_WIDTH'(FB_HEIGHT / 2);
  localparam logic signed [FP_WIDTH-1:0] QTR_W  = FP_WIDTH'(FB_WIDTH / 4);
  localparam logic signed [FP_WIDTH-1:0] QTR_H  = FP_WIDTH'(FB_HEIGHT / 4);

  localparam int            TW       = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CHECK,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t state, state_n;

  logic signed [FP_WIDTH-1:0] x_q, y_q, step_q;
  logic signed [FP_WIDTH-1:0] x_n, y_n, step_n;
  logic signed [FP_WIDTH-1:0] x_c, y_c, step_c;
  logic signed [FP_WIDTH-1:0] x_cand, y_cand, step_cand;
  logic signed [FP_WIDTH-1:0] pan;
  logic [1:0]                 mode_q;
  logic                       start_q, start_n;
  logic                       reject_q, reject_n;
  logic                       idle_q;
  logic                       auto_q;
  logic                       auto_req;
  logic                       btn_req;
  logic                       req;
  logic                       cand_ok;
  logic [TW-1:0]              tmo_cnt;

`ifdef MANDEL_AUTOZOOM_EN
  assign auto_req = vif.frame && vif.auto_en && !vif.up && !vif.dn;
`else
  assign auto_req = 1'b0;
`endif

  assign btn_req = vif.frame && (vif.up || vif.dn);
  assign req     = btn_req || auto_req;
  assign pan     = step_q <<< MOVE_SHIFT;
  assign cand_ok = (step_cand != '0) && (step_cand <= STEP_MAX);

  // Candidate view from the current outputs; up wins over dn, auto request is always a zoom-in.
  always_comb begin
    x_c    = x_q;
    y_c    = y_q;
    step_c = step_q;
    if (auto_req || mode_q == MODE_ZOOM) begin
      if (vif.up) begin
        x_c    = x_q - step_q * HALF_W;
        y_c    = y_q - step_q * HALF_H;
        step_c = step_q <<< 1;
      end else begin
        x_c    = x_q + step_q * QTR_W;
        y_c    = y_q + step_q * QTR_H;
        step_c = step_q >>> 1;
      end
    end else if (mode_q == MODE_VERT) begin
      y_c = vif.up ? (y_q - pan) : (y_q + pan);
    end else if (mode_q == MODE_HORZ) begin
      x_c = vif.up ? (x_q - pan) : (x_q + pan);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_INIT:      state_n = S_WAIT_BUSY;
      S_IDLE:      if (req) state_n = S_CHECK;
      S_CHECK:     state_n = cand_ok ? S_WAIT_BUSY : (auto_q ? S_INIT : S_IDLE);
      S_WAIT_BUSY: begin
        if (vif.render_busy) begin
          state_n = S_WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n = S_IDLE;
        end
      end
      S_WAIT_DONE: if (!vif.render_busy) state_n = S_IDLE;
      default:     state_n = S_INIT;
    endcase
  end

  // INIT doubles as the home-view reload after a refused auto zoom.
  always_comb begin
    x_n      = x_q;
    y_n      = y_q;
    step_n   = step_q;
    start_n  = 1'b0;
    reject_n = 1'b0;
    unique case (state)
      S_INIT: begin
        x_n     = X_START;
        y_n     = Y_START;
        step_n  = STEP_MAX;
        start_n = 1'b1;
      end
      S_CHECK: begin
        if (cand_ok) begin
          x_n     = x_cand;
          y_n     = y_cand;
          step_n  = step_cand;
          start_n = 1'b1;
        end else begin
          reject_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= X_START;
      y_q      <= Y_START;
      step_q   <= STEP_MAX;
      start_q  <= 1'b0;
      reject_q <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      x_q      <= x_n;
      y_q      <= y_n;
      step_q   <= step_n;
      start_q  <= start_n;
      reject_q <= reject_n;
      idle_q   <= (state_n == S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cand    <= X_START;
      y_cand    <= Y_START;
      step_cand <= STEP_MAX;
      auto_q    <= 1'b0;
    end else if (state == S_IDLE && req) begin
      x_cand    <= x_c;
      y_cand    <= y_c;
      step_cand <= step_c;
      auto_q    <= auto_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_HORZ;
    end else if (vif.sel) begin
      mode_q <= (mode_q == MODE_ZOOM) ? MODE_HORZ : (mode_q + 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT_BUSY) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign vif.render_start = start_q;
  assign vif.x_start      = x_q;
  assign vif.y_start      = y_q;
  assign vif.step         = step_q;
  assign vif.mode         = mode_q;
  assign vif.reject       = reject_q;
  assign vif.idle         = idle_q;

endmodule

// File: doc/mandel_view_ctrl.md
Name: mandel_view_ctrl

Overview:
- Sequences the Mandelbrot render engine: turns debounced user requests into pan/zoom view parameters (x_start, y_start, step) and issues a one-cycle render start.
- Holds new requests off while a render is in flight, and rejects zoom requests that fall outside the step limits.
- Sits in the system clock domain between the debouncers and frame-flag synchroniser on one side and render_mandel on the other.

Parameters:
- FP_WIDTH, 25: width of signed fixed-point coordinates (4 integer bits).
- X_START, 25'h1900000: reset left coordinate (-3.5).
- Y_START, 25'h1D00000: reset top coordinate (-1.5).
- STEP_MAX, 25'h0008000: reset step and maximum legal step (1/64).
- FB_WIDTH, 320: framebuffer width in pixels; sets the zoom offsets.
- FB_HEIGHT, 180: framebuffer height in pixels; sets the zoom offsets.
- MOVE_SHIFT, 4: a pan moves by step<<<MOVE_SHIFT.
- BUSY_TIMEOUT, 15: maximum cycles to wait for render_busy to rise after a start.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame  in  1  one-cycle frame-start pulse in the clk domain.
- sel  in  1  one-cycle pulse; advances mode.
- up  in  1  level, debounced.
- dn  in  1  level, debounced.
- render_busy  in  1  render engine busy.
- render_start  out  1  one-cycle render start pulse.
- x_start  out  FP_WIDTH  signed left coordinate.
- y_start  out  FP_WIDTH  signed top coordinate.
- step  out  FP_WIDTH  signed coordinate step.
- mode  out  2  0=HORIZONTAL, 1=VERTICAL, 2=ZOOM.
- reject  out  1  one-cycle pulse when a request is refused.
- idle  out  1  high when the controller is in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - x_start=X_START, y_start=Y_START, step=STEP_MAX, mode=0.
  - render_start=0, reject=0, idle=0, state=INIT.
  - Applies immediately, including mid-render; any pending candidate is discarded.
- States: INIT, IDLE, CHECK, WAIT_BUSY, WAIT_DONE. All outputs are registered.
- INIT: at the first edge after rst_n rises, render_start<=1 and the FSM goes to WAIT_BUSY (initial render).
- IDLE: when frame && (up||dn), compute the candidate x/y/step registers and go to CHECK.
  - up has priority when both up and dn are high.
  - frame without up/dn does nothing.
- Candidate arithmetic uses the current outputs, FP_WIDTH-bit two's complement, and wraps without saturation.
  - HORIZONTAL: x -= step<<<MOVE_SHIFT (up); x += step<<<MOVE_SHIFT (dn).
  - VERTICAL: y -= step<<<MOVE_SHIFT (up); y += step<<<MOVE_SHIFT (dn).
  - ZOOM out (up): x -= step*(FB_WIDTH/2); y -= step*(FB_HEIGHT/2); step = step<<<1.
  - ZOOM in (dn): x += step*(FB_WIDTH/4); y += step*(FB_HEIGHT/4); step = step>>>1.
- CHECK: a candidate is valid iff step_c != 0 and step_c <= STEP_MAX (signed compare).
  - Valid: outputs take the candidate, render_start<=1, go to WAIT_BUSY.
  - Invalid: outputs are unchanged, reject<=1 for one cycle, go to IDLE.
- Latency: render_start is high two cycles after the frame cycle, coincident with the new parameters.
- WAIT_BUSY: go to WAIT_DONE on render_busy=1. If BUSY_TIMEOUT cycles pass without it, go to IDLE; no retry.
- WAIT_DONE: go to IDLE on render_busy=0.
- Requests: frame/up/dn are ignored in every state except IDLE; nothing is queued.
- mode: advances on sel in any state, 0→1→2→0.
  - Mode is latched into the candidate at the IDLE decision; a sel during CHECK does not alter the request in flight.
- idle = (state==IDLE).

Optional Feature:
- Macro MANDEL_AUTOZOOM_EN adds input port auto_en (1 bit).
- With the macro:
  - In IDLE, frame && auto_en && !up && !dn acts as a ZOOM-in request regardless of mode.
  - If that request is rejected, reject pulses, then x/y/step reload X_START/Y_START/STEP_MAX on the next cycle, render_start pulses, and the FSM goes to WAIT_BUSY.
- Without the macro: the port is absent and behaviour is buttons only.

Test Plan:
- Reset release with render_busy high 1 cycle after start, low 10 cycles later → one render_start pulse, params 1900000/1D00000/0008000, idle after busy falls.
- mode=0, frame with up → render_start 2 cycles later, x_start=25'h1880000, y/step unchanged; dn next frame → x back to 25'h1900000.
- mode=2, frame with dn → x=25'h1B80000, y=25'h1E68000, step=25'h0004000; then frame with up → original params restored.
- mode=2 at reset params, frame with up → reject pulses 2 cycles later, no render_start, params unchanged. Also step=1 with zoom-in → reject.
- Frame plus up during WAIT_DONE → ignored. render_busy never rises → idle after 15 cycles. Assert rst_n mid-WAIT_DONE → outputs to reset values immediately and the initial render is re-issued.
- sel pulsed 3 times → mode 1,2,0. Simultaneous up and dn in mode 1 → y decreases by 25'h80000.
